// File: rtl/shift_reg_piso_serializer_pkg.sv
// Shared types and helpers for the PISO serializer.
//   piso_state_e : FSM encoding (StIdle=0, StShift=1)
//   WidthMin/Max : legal range of the WIDTH parameter
//   width_legal  : WIDTH legality check, reusable by neighbouring shift-register blocks
//   is_pend      : PEND flag, a word accepted but its first bit not yet emitted
package shift_reg_piso_serializer_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } piso_state_e;

  localparam int unsigned WidthMin = 2;
  localparam int unsigned WidthMax = 32;

  function automatic bit width_legal(int unsigned width);
    return (width >= WidthMin) && (width <= WidthMax);
  endfunction

  // PEND: in SHIFT with no bit emitted yet (accepted while bit_en was low).
  function automatic logic is_pend(piso_state_e state, logic count_zero);
    return (state == StShift) && count_zero;
  endfunction

endpackage

// File: rtl/shift_reg_piso_serializer_if.sv
// Handshake and serial-output bundle of the PISO serializer.
//   bit_en      : shift strobe from the bit-rate timing source
//   load_data   : parallel word, load_valid / load_ready handshake
//   q           : serial data out, q_valid / frame_start qualifiers
//   busy        : a frame is in progress
// master = upstream word source and downstream observer; slave = serializer.
interface shift_reg_piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             bit_en;
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             q;
  logic             q_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output bit_en,
    output load_data,
    output load_valid,
    input  load_ready,
    input  q,
    input  q_valid,
    input  frame_start,
    input  busy
  );

  modport slave (
    input  bit_en,
    input  load_data,
    input  load_valid,
    output load_ready,
    output q,
    output q_valid,
    output frame_start,
    output busy
  );

endinterface

// File: rtl/shift_reg_piso_serializer_bit_counter.sv
// Saturating bit counter for the PISO serializer.
//   clk_i   : rising-edge clock
//   reset_i : synchronous active-high reset, clears the count
//   load_i  : restart the count; with inc_i the restart value is 1, otherwise 0
//   inc_i   : advance by one (saturates at MAX, never wraps)
//   count_o : bits emitted in the current frame
//   last_o  : count_o == MAX, the last bit of the frame is on q
module shift_reg_piso_serializer_bit_counter #(
  parameter int unsigned MAX = 8,
  localparam int unsigned CntW = $clog2(MAX + 1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            load_i,
  input  logic            inc_i,
  output logic [CntW-1:0] count_o,
  output logic            last_o
);

  localparam logic [CntW-1:0] MaxVal = CntW'(MAX);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = inc_i ? CntW'(1) : '0;
    end else if (inc_i && (count_q != MaxVal)) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == MaxVal);

endmodule

// File: rtl/shift_reg_piso_serializer.sv
// Parallel-in serial-out stage feeding the shift_reg_siso delay line.
// A WIDTH-bit word is accepted over a valid/ready handshake and emitted one bit per cycle
// with bit_en=1. q, q_valid and frame_start are registered; load_ready is combinational.
// Parameters:
//   WIDTH      : word width, 2..32
//   MSB_FIRST  : 1 emits bit WIDTH-1 first (shift left), 0 emits bit 0 first (shift right)
//   IDLE_LEVEL : level driven on q outside a frame
// Ports:
//   clk_i   : rising-edge clock
//   reset_i : synchronous active-high reset; aborts any frame in progress
//   bus_io  : slave side of the handshake / serial-output bundle
module shift_reg_piso_serializer
  import shift_reg_piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  shift_reg_piso_serializer_if.slave  bus_io
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  if (!width_legal(WIDTH)) begin : gen_width_check
    $error("shift_reg_piso_serializer: WIDTH must be within 2..32");
  end

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             fs_q, fs_d;

  logic             cnt_load;
  logic             cnt_inc;
  logic [CntW-1:0]  cnt;
  logic             cnt_last;

  logic             load_ready;
  logic             accept;
  logic             pend;

  // Bit that leaves the word first, and the word after that bit has left.
  function automatic logic head_bit(logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  shift_reg_piso_serializer_bit_counter #(
    .MAX (WIDTH)
  ) u_bit_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (cnt_load),
    .inc_i   (cnt_inc),
    .count_o (cnt),
    .last_o  (cnt_last)
  );

  // In SHIFT a new word is only taken when the edge that would end the frame arrives, so the
  // next frame's first bit replaces the idle cycle.
  assign load_ready = ~reset_i &
                      ((state_q == StIdle) |
                       ((state_q == StShift) & cnt_last & bus_io.bit_en));
  assign accept     = bus_io.load_valid & load_ready;
  assign pend       = is_pend(state_q, cnt == '0);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    fs_d      = fs_q;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;

    if (accept) begin
      state_d  = StShift;
      shreg_d  = bus_io.load_data;
      cnt_load = 1'b1;
      if (bus_io.bit_en) begin
        // First bit goes out at the accept edge itself.
        q_d       = head_bit(bus_io.load_data);
        shreg_d   = advance(bus_io.load_data);
        q_valid_d = 1'b1;
        fs_d      = 1'b1;
        cnt_inc   = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          // Nothing to do until a word is offered.
        end
        StShift: begin
          if (bus_io.bit_en) begin
            if (cnt_last) begin
              state_d   = StIdle;
              q_d       = IDLE_LEVEL;
              q_valid_d = 1'b0;
              fs_d      = 1'b0;
              cnt_load  = 1'b1;
            end else begin
              q_d       = head_bit(shreg_q);
              shreg_d   = advance(shreg_q);
              q_valid_d = 1'b1;
              fs_d      = pend;
              cnt_inc   = 1'b1;
            end
          end
          // bit_en=0: q, qualifiers and count hold.
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      q_q       <= IDLE_LEVEL;
      q_valid_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      fs_q      <= fs_d;
    end
  end

  assign bus_io.load_ready  = load_ready;
  assign bus_io.q           = q_q;
  assign bus_io.q_valid     = q_valid_q;
  assign bus_io.frame_start = fs_q;
  assign bus_io.busy        = (state_q == StShift);

endmodule
